// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Shares one single-port synchronous RAM between three requesters: the
// stage12 fetch read, the stage3 load read and the stage5 store write.
// A three-state FSM (IDLE -> ACCESS -> COMPLETE) serializes the accesses,
// so there is one access every three cycles. The fixed priority is
// store > load > fetch. Aging overrides it: a requester that has lost
// STARVE_LIMIT arbitrations in a row goes to the top.
//
// Ports
//   ram_clk, rst                 clock and synchronous active-high reset
//   fetch_read / load_read       level read requests; *_address held while high
//   *_read_ready                 one-cycle completion pulse to the winner only
//   *_read_data_out              read data; shown live during COMPLETE, then held
//   store_save                   level write request with address and data
//   store_save_ready             one-cycle completion pulse
//   ram_write_enable/address/data_in   registered drive into the RAM
//   ram_data_out                 registered read data coming back from the RAM
//   busy                         high whenever the FSM is not in IDLE
//   grant_id                     0 none, 1 fetch, 2 load, 3 store (while busy)
module ram_access_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              ram_clk,
  input  logic              rst,
  input  logic              fetch_read,
  output logic              fetch_read_ready,
  input  logic [ADDR_W-1:0] fetch_read_address,
  output logic [DATA_W-1:0] fetch_read_data_out,
  input  logic              load_read,
  output logic              load_read_ready,
  input  logic [ADDR_W-1:0] load_read_address,
  output logic [DATA_W-1:0] load_read_data_out,
  input  logic              store_save,
  output logic              store_save_ready,
  input  logic [ADDR_W-1:0] store_save_address,
  input  logic [DATA_W-1:0] store_save_data_in,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic [1:0]        grant_id
);

  localparam logic [1:0] GID_NONE  = 2'd0;
  localparam logic [1:0] GID_FETCH = 2'd1;
  localparam logic [1:0] GID_LOAD  = 2'd2;
  localparam logic [1:0] GID_STORE = 2'd3;

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam bit               AGING_EN = (STARVE_LIMIT != 0);

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] fetch_data_q;
  logic [DATA_W-1:0] load_data_q;

  // Bit index i belongs to grant id i+1: 0 fetch, 1 load, 2 store.
  logic [2:0] req;
  logic [2:0] starved;
  logic [1:0] win_id;

  assign req = {store_save, load_read, fetch_read};

  // Per-requester starvation counter. A counter only moves at a grant
  // decision (IDLE with any request pending) or when its request drops.
  for (genvar gi = 0; gi < 3; gi++) begin : g_age
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign starved[gi] = AGING_EN && req[gi] && (cnt_q == LIMIT);

    always_comb begin
      cnt_d = cnt_q;
      if (!req[gi]) begin
        cnt_d = '0;
      end else if (state_q == IDLE) begin
        if (win_id == 2'(gi + 1)) begin
          cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge ram_clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  // Winner selection: a starved requester beats any fixed-priority winner.
  // Among several starved requesters the fixed order still applies.
  always_comb begin
    win_id = GID_NONE;
    if (starved[2])      win_id = GID_STORE;
    else if (starved[1]) win_id = GID_LOAD;
    else if (starved[0]) win_id = GID_FETCH;
    else if (req[2])     win_id = GID_STORE;
    else if (req[1])     win_id = GID_LOAD;
    else if (req[0])     win_id = GID_FETCH;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (|req) state_d = ACCESS;
      ACCESS:   state_d = COMPLETE;
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge ram_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= GID_NONE;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      fetch_data_q <= '0;
      load_data_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q <= win_id;
            // The RAM drive is registered here, so it is stable for the
            // whole ACCESS cycle and the RAM samples it at the closing edge.
            we_q <= (win_id == GID_STORE);
            case (win_id)
              GID_STORE: begin
                addr_q  <= store_save_address;
                wdata_q <= store_save_data_in;
              end
              GID_LOAD: addr_q <= load_read_address;
              default:  addr_q <= fetch_read_address;
            endcase
          end
        end
        ACCESS: we_q <= 1'b0;
        COMPLETE: begin
          if (grant_q == GID_FETCH) fetch_data_q <= ram_data_out;
          if (grant_q == GID_LOAD)  load_data_q  <= ram_data_out;
        end
        default: ;
      endcase
    end
  end

  // Ready is gated by rst, so an access aborted in COMPLETE never
  // signals completion to its requester.
  logic complete_now;
  assign complete_now = (state_q == COMPLETE) && !rst;

  assign fetch_read_ready = complete_now && (grant_q == GID_FETCH);
  assign load_read_ready  = complete_now && (grant_q == GID_LOAD);
  assign store_save_ready = complete_now && (grant_q == GID_STORE);

  // During COMPLETE the RAM's registered output already holds the read
  // data, so pass it straight through instead of waiting a cycle.
  assign fetch_read_data_out = ((state_q == COMPLETE) && (grant_q == GID_FETCH))
                               ? ram_data_out : fetch_data_q;
  assign load_read_data_out  = ((state_q == COMPLETE) && (grant_q == GID_LOAD))
                               ? ram_data_out : load_data_q;

  assign ram_write_enable = we_q;
  assign ram_address      = addr_q;
  assign ram_data_in      = wdata_q;

  assign busy     = (state_q != IDLE);
  assign grant_id = busy ? grant_q : GID_NONE;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: directed scenarios followed by random
// traffic. A transaction-level model holds the expected memory contents,
// the aging counters and the grant schedule. A compare process checks the
// DUT against that model on every cycle.
module tb_ram_access_arbiter;
  localparam int SL = 2;

  logic        clk;
  logic        rst;
  logic [2:0]  tb_req;
  logic [15:0] tb_addr [3];
  logic [7:0]  tb_wdata;

  logic        fetch_read_ready, load_read_ready, store_save_ready;
  logic [7:0]  fetch_read_data_out, load_read_data_out;
  logic        ram_write_enable;
  logic [15:0] ram_address;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_dout;
  logic        busy;
  logic [1:0]  grant_id;
  logic [2:0]  dut_rdy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ram_access_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(SL), .CNT_W(3)) dut (
    .ram_clk(clk), .rst(rst),
    .fetch_read(tb_req[0]), .fetch_read_ready(fetch_read_ready),
    .fetch_read_address(tb_addr[0]), .fetch_read_data_out(fetch_read_data_out),
    .load_read(tb_req[1]), .load_read_ready(load_read_ready),
    .load_read_address(tb_addr[1]), .load_read_data_out(load_read_data_out),
    .store_save(tb_req[2]), .store_save_ready(store_save_ready),
    .store_save_address(tb_addr[2]), .store_save_data_in(tb_wdata),
    .ram_write_enable(ram_write_enable), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_dout),
    .busy(busy), .grant_id(grant_id)
  );

  assign dut_rdy = {store_save_ready, load_read_ready, fetch_read_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The single-port RAM the arbiter drives. It is not reset.
  logic [7:0] ram_mem   [0:65535];
  logic [7:0] model_mem [0:65535];

  always @(posedge clk) begin
    if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
    ram_dout <= ram_mem[ram_address];
  end

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return (a[7:0] ^ a[15:8]) + 8'd1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase counts the cycles left in the current access: 2 while the RAM
  // is being driven, 1 in the completion cycle, 0 when nothing is in flight.
  int          m_phase = 0;
  int          m_win = 0;
  int          m_cnt [3];
  logic        m_valid = 1'b0;
  logic        m_rst_last = 1'b0;
  logic [15:0] m_addr;
  logic [7:0]  m_wd;
  logic [7:0]  m_rdata;
  logic [7:0]  m_dout [2];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_valid = 1'b1;
      m_rst_last = 1'b1;
      m_phase = 0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_dout[0] = 8'h00;
      m_dout[1] = 8'h00;
    end else begin
      m_rst_last = 1'b0;
      if (m_phase == 1) begin
        if (m_win != 2) m_dout[m_win] = m_rdata;
        m_phase = 0;
      end else if (m_phase == 2) begin
        m_phase = 1;
      end else if (tb_req != 3'b000) begin
        int w;
        w = -1;
        for (int i = 2; i >= 0; i--)
          if (w < 0 && tb_req[i] && SL != 0 && m_cnt[i] == SL) w = i;
        for (int i = 2; i >= 0; i--)
          if (w < 0 && tb_req[i]) w = i;
        for (int i = 0; i < 3; i++) begin
          if (i == w) m_cnt[i] = 0;
          else if (tb_req[i] && m_cnt[i] < SL) m_cnt[i]++;
        end
        m_win = w;
        m_addr = tb_addr[w];
        m_phase = 2;
        if (w == 2) begin
          m_wd = tb_wdata;
          model_mem[m_addr] = tb_wdata;
        end else begin
          m_rdata = model_mem[m_addr];
        end
      end
      for (int i = 0; i < 3; i++) if (!tb_req[i]) m_cnt[i] = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", int'(busy), int'(m_phase != 0));
      chk("grant_id", int'(grant_id), (m_phase != 0) ? m_win + 1 : 0);
      for (int i = 0; i < 3; i++)
        chk($sformatf("ready%0d", i), int'(dut_rdy[i]),
            int'(m_phase == 1 && m_win == i && !rst));
      chk("fetch_dout", int'(fetch_read_data_out),
          int'((m_phase == 1 && m_win == 0) ? m_rdata : m_dout[0]));
      chk("load_dout", int'(load_read_data_out),
          int'((m_phase == 1 && m_win == 1) ? m_rdata : m_dout[1]));
      chk("ram_we", int'(ram_write_enable), int'(m_phase == 2 && m_win == 2));
      if (m_phase == 2) begin
        chk("ram_address", int'(ram_address), int'(m_addr));
        if (m_win == 2) chk("ram_data_in", int'(ram_data_in), int'(m_wd));
      end
      if (m_rst_last) begin
        chk("rst_ram_address", int'(ram_address), 0);
        chk("rst_ram_data_in", int'(ram_data_in), 0);
      end
      if (m_phase == 1 && !rst)
        $display("txn cycle=%0d port=%0d addr=%h data=%h", cyc, m_win, m_addr,
                 (m_win == 2) ? m_wd : m_rdata);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dout_of(input int who);
    return (who == 0) ? fetch_read_data_out : load_read_data_out;
  endfunction

  // Call this one time unit after a posedge while the DUT is idle.
  task automatic single(input int who, input logic [15:0] a, input logic [7:0] d,
                        input int exp_rd, input string tag);
    tb_addr[who] = a;
    if (who == 2) tb_wdata = d;
    tb_req[who] = 1'b1;
    @(negedge clk);
    chk({tag, "_pre_busy"}, int'(busy), 0);
    chk({tag, "_pre_we"}, int'(ram_write_enable), 0);
    @(negedge clk);
    chk({tag, "_acc_gid"}, int'(grant_id), who + 1);
    chk({tag, "_acc_we"}, int'(ram_write_enable), int'(who == 2));
    chk({tag, "_acc_ready"}, int'(dut_rdy[who]), 0);
    @(negedge clk);
    chk({tag, "_cmp_ready"}, int'(dut_rdy[who]), 1);
    chk({tag, "_cmp_we"}, int'(ram_write_enable), 0);
    if (who != 2) chk({tag, "_cmp_data"}, int'(dout_of(who)), exp_rd);
    tick();
    tb_req[who] = 1'b0;
  endtask

  int         ord [3];
  int         cy  [3];
  int         got [3];
  int         n;
  int         seq [6];
  int         exp4 [6];
  logic [2:0] seen;
  logic       found;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i]   = init_val(16'(i));
      model_mem[i] = init_val(16'(i));
    end
    rst = 1'b1;
    tb_req = 3'b000;
    for (int i = 0; i < 3; i++) tb_addr[i] = 16'h0000;
    tb_wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_gid", int'(grant_id), 0);
    chk("reset_we", int'(ram_write_enable), 0);
    chk("reset_addr", int'(ram_address), 0);
    chk("reset_ready", int'(dut_rdy), 0);
    chk("reset_fetch_dout", int'(fetch_read_data_out), 0);
    tick();
    rst = 1'b0;

    // 1: single fetch of address 0
    single(0, 16'h0000, 8'h00, 'h01, "t1");

    // 2: store then readback
    single(2, 16'h0020, 8'hAB, 0, "t2_store");
    single(1, 16'h0020, 8'h00, 'hAB, "t2_load");

    // 3: all three requests raised together
    tb_addr[0] = 16'h0300; tb_addr[1] = 16'h0200; tb_addr[2] = 16'h0100;
    tb_wdata = 8'h5A;
    tb_req = 3'b111;
    n = 0;
    for (int i = 0; i < 3; i++) begin ord[i] = 9; cy[i] = 0; got[i] = 0; end
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (dut_rdy[i] && n < 3) begin
          ord[n] = i; cy[n] = c; got[i] = int'(dout_of(i)); n++;
        end
      seen = dut_rdy;
      tick();
      for (int i = 0; i < 3; i++) if (seen[i]) tb_req[i] = 1'b0;
    end
    tb_req = 3'b000;
    chk("t3_count", n, 3);
    chk("t3_first", ord[0], 2);
    chk("t3_second", ord[1], 1);
    chk("t3_third", ord[2], 0);
    chk("t3_gap1", cy[1] - cy[0], 3);
    chk("t3_gap2", cy[2] - cy[1], 3);
    chk("t3_load_data", got[1], 'h03);
    chk("t3_fetch_data", got[0], 'h04);

    // 4: aging with fetch and load held continuously
    tb_addr[0] = 16'h0010; tb_addr[1] = 16'h0011;
    tb_req = 3'b011;
    n = 0;
    exp4 = '{1, 1, 0, 1, 1, 0};
    for (int i = 0; i < 6; i++) seq[i] = 9;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (dut_rdy[i] && n < 6) begin seq[n] = i; n++; end
      tick();
    end
    tb_req = 3'b000;
    chk("t4_count", n, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t4_grant%0d", i), seq[i], exp4[i]);

    // 5: reset during COMPLETE of a load
    tick();
    tb_addr[1] = 16'h0040;
    tb_req[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_acc_gid", int'(grant_id), 2);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_no_ready", int'(load_read_ready), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", int'(busy), 0);
    chk("t5_load_dout", int'(load_read_data_out), 0);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (load_read_ready) begin
        found = 1'b1;
        chk("t5_retry_data", int'(load_read_data_out), 'h41);
      end
    end
    chk("t5_retry_ready", int'(found), 1);
    tick();
    tb_req[1] = 1'b0;

    // 6: reset at the edge closing a store's ACCESS cycle
    tick();
    tb_addr[2] = 16'h0080;
    tb_wdata = 8'hC3;
    tb_req[2] = 1'b1;
    tick();
    rst = 1'b1;
    tb_req[2] = 1'b0;
    @(negedge clk);
    chk("t6_acc_we", int'(ram_write_enable), 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", int'(busy), 0);
    chk("t6_we", int'(ram_write_enable), 0);
    chk("t6_addr", int'(ram_address), 0);
    chk("t6_din", int'(ram_data_in), 0);
    chk("t6_gid", int'(grant_id), 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t6_no_store_ready", int'(store_save_ready), 0);
    end
    chk("t6_ram_value", int'(ram_mem[16'h0080]), 'hC3);
    tick();
    single(1, 16'h0080, 8'h00, 'hC3, "t6_readback");

    // Random traffic with occasional resets
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      seen = dut_rdy;
      tick();
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!tb_req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            tb_req[i] = 1'b1;
            tb_addr[i] = 16'($urandom_range(0, 31));
            if (i == 2) tb_wdata = 8'($urandom);
          end
        end else if (seen[i]) begin
          if ($urandom_range(0, 1) == 0) begin
            tb_req[i] = 1'b0;
          end else begin
            tb_addr[i] = 16'($urandom_range(0, 31));
            if (i == 2) tb_wdata = 8'($urandom);
          end
        end
      end
    end
    rst = 1'b0;
    tb_req = 3'b000;
    repeat (6) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
